// File: rtl/hamming_decoder_if.sv
// Bus bundle for the SECDED decoder stage.
//   slave  : decoder side (takes codewords and out_ready, drives results and counters)
//   master : environment side (drives codewords and out_ready, observes results)
// Signals:
//   in_valid/in_ready/code                          input handshake and received codeword
//   out_valid/out_ready/data/single_err/double_err/err_pos   result handshake and payload
//   clear_cnt/corr_cnt/uncorr_cnt                   error counter control and status
interface hamming_decoder_if #(
  parameter int DATA_WIDTH = 39,
  parameter int CNT_WIDTH  = 16
);
  function automatic int calc_addr_width(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int ADDR_WIDTH  = calc_addr_width(DATA_WIDTH);
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [CODED_WIDTH-1:0] code;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  data;
  logic                   single_err;
  logic                   double_err;
  logic [ADDR_WIDTH-1:0]  err_pos;
  logic                   clear_cnt;
  logic [CNT_WIDTH-1:0]   corr_cnt;
  logic [CNT_WIDTH-1:0]   uncorr_cnt;

  modport slave (
    input  in_valid, code, out_ready, clear_cnt,
    output in_ready, out_valid, data, single_err, double_err, err_pos, corr_cnt, uncorr_cnt
  );

  modport master (
    output in_valid, code, out_ready, clear_cnt,
    input  in_ready, out_valid, data, single_err, double_err, err_pos, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/hamming_decoder.sv
// SECDED check/correct stage for extended-Hamming codewords
// (bit 0 = overall parity, bits 2^i = check bits, remaining positions = payload).
// Two-register valid/ready pipeline:
//   stage 1 registers the codeword with its syndrome and overall parity,
//   stage 2 registers the classified, corrected and extracted result.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous reset, active low (drops in-flight words, clears counters)
//   bus      hamming_decoder_if.slave (handshakes, result, error counters)
module hamming_decoder #(
  parameter int DATA_WIDTH = 39,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  hamming_decoder_if.slave bus
);
  function automatic int calc_addr_width(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int ADDR_WIDTH  = calc_addr_width(DATA_WIDTH);
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int STAGES      = 2;
  localparam logic [ADDR_WIDTH:0] CW_L = (ADDR_WIDTH+1)'(CODED_WIDTH);

  // Codeword position holding payload bit k: the k-th non-power-of-two index above 0.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == k) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

  logic [STAGES:1]        vld_pipe;
  logic                   s2_free;

  logic [ADDR_WIDTH-1:0]  syn_c;
  logic                   par_c;
  logic [CODED_WIDTH-1:0] s1_code;
  logic [ADDR_WIDTH-1:0]  s1_syn;
  logic                   s1_par;

  logic                   single_c;
  logic                   double_c;
  logic [CODED_WIDTH-1:0] corr_c;
  logic [DATA_WIDTH-1:0]  data_c;

  logic [DATA_WIDTH-1:0]  data_q;
  logic                   single_q;
  logic                   double_q;
  logic [ADDR_WIDTH-1:0]  pos_q;
  logic [CNT_WIDTH-1:0]   corr_q;
  logic [CNT_WIDTH-1:0]   uncorr_q;
  logic                   out_hs;

  // Output register is free when empty or being drained; input side follows.
  assign s2_free      = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !vld_pipe[1] || s2_free;

  always_comb begin
    syn_c = '0;
    par_c = bus.code[0];
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if (bus.code[i]) syn_c = syn_c ^ ADDR_WIDTH'(i);
      par_c = par_c ^ bus.code[i];
    end
  end

  // Odd parity with a syndrome pointing inside the word is a single flip;
  // any other nonzero evidence is uncorrectable.
  always_comb begin
    single_c = s1_par && ({1'b0, s1_syn} < CW_L);
    double_c = (s1_par && !({1'b0, s1_syn} < CW_L)) || (!s1_par && (s1_syn != '0));
    corr_c   = s1_code;
    if (single_c) corr_c = s1_code ^ (CODED_WIDTH'(1) << s1_syn);
  end

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_ext
    assign data_c[k] = corr_c[data_pos(k)];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      data_q   <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      pos_q    <= '0;
    end else begin
      if (bus.in_ready) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          s1_code <= bus.code;
          s1_syn  <= syn_c;
          s1_par  <= par_c;
        end
      end
      // Only refill the output on a real word so a held result never changes.
      if (s2_free) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          data_q   <= data_c;
          single_q <= single_c;
          double_q <= double_c;
          pos_q    <= s1_syn;
        end
      end
    end
  end

  assign out_hs = vld_pipe[2] && bus.out_ready;

  // Clear takes priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (bus.clear_cnt) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (out_hs) begin
      if (single_q && (corr_q != '1))   corr_q   <= corr_q + 1'b1;
      if (double_q && (uncorr_q != '1)) uncorr_q <= uncorr_q + 1'b1;
    end
  end

  assign bus.out_valid  = vld_pipe[2];
  assign bus.data       = data_q;
  assign bus.single_err = single_q;
  assign bus.double_err = double_q;
  assign bus.err_pos    = pos_q;
  assign bus.corr_cnt   = corr_q;
  assign bus.uncorr_cnt = uncorr_q;
endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed steps plus a randomized stream, checked
// against a reference built from the codeword rules (encode, inject, expect).
// A second instance with 2-bit counters shares the stimulus to cover saturation.
module tb_hamming_decoder;
  localparam int DW = 39;
  localparam int CW = 46;
  localparam int AW = 6;

  typedef struct {
    logic [DW-1:0] data;
    logic          single;
    logic          dbl;
    logic [AW-1:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_decoder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
  hamming_decoder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2))  bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.code      = bus.code;
  assign bus2.out_ready = bus.out_ready;
  assign bus2.clear_cnt = bus.clear_cnt;

  hamming_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );
  hamming_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  exp_t q[$];
  exp_t cur_exp;
  logic accepted;
  logic saw_low;
  int   m_corr, m_unc, m_corr2, m_unc2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] w;
    int k;
    int s;
    w = '0;
    k = 0;
    s = 0;
    for (int i = 1; i < CW; i++)
      if ((i & (i - 1)) != 0) begin
        w[i] = d[k];
        k++;
      end
    for (int i = 1; i < CW; i++) if (w[i]) s = s ^ i;
    for (int j = 0; j < AW; j++) w[1 << j] = s[j];
    w[0] = ^w;
    return w;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] w);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = w[i];
        k++;
      end
    return d;
  endfunction

  // Present a word with nerr flipped positions and record what must come out.
  task automatic prep(input logic [DW-1:0] d, input int nerr, input int e1, input int e2);
    logic [CW-1:0] w;
    w = encode(d);
    if (nerr >= 1) w[e1] = ~w[e1];
    if (nerr == 2) w[e2] = ~w[e2];
    bus.code       = w;
    cur_exp.data   = (nerr == 2) ? extract(w) : d;
    cur_exp.single = (nerr == 1);
    cur_exp.dbl    = (nerr == 2);
    cur_exp.pos    = (nerr == 0) ? '0 : (nerr == 1) ? AW'(e1) : AW'(e1 ^ e2);
  endtask

  // One clock: check at the falling edge, update the model, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    chk("corr_cnt", 64'(bus.corr_cnt), 64'(m_corr));
    chk("uncorr_cnt", 64'(bus.uncorr_cnt), 64'(m_unc));
    chk("corr_cnt_w2", 64'(bus2.corr_cnt), 64'(m_corr2));
    chk("uncorr_cnt_w2", 64'(bus2.uncorr_cnt), 64'(m_unc2));
    chk("in_ready", 64'(bus.in_ready), 64'(!(q.size() == 2 && !bus.out_ready)));
    if (!bus.in_ready) saw_low = 1'b1;
    if (bus.out_valid) begin
      if (q.size() == 0) chk("spurious_out", 64'(bus.out_valid), 64'(0));
      else begin
        e = q[0];
        chk("data", 64'(bus.data), 64'(e.data));
        chk("single_err", 64'(bus.single_err), 64'(e.single));
        chk("double_err", 64'(bus.double_err), 64'(e.dbl));
        chk("err_pos", 64'(bus.err_pos), 64'(e.pos));
        if (bus.out_ready) begin
          void'(q.pop_front());
          n_out++;
          if (e.single) begin
            if (m_corr != 65535) m_corr++;
            if (m_corr2 != 3) m_corr2++;
          end
          if (e.dbl) begin
            if (m_unc != 65535) m_unc++;
            if (m_unc2 != 3) m_unc2++;
          end
        end
      end
    end
    if (bus.clear_cnt) begin
      m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
    end
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input int nerr, input int e1, input int e2);
    int g;
    prep(d, nerr, e1, e2);
    bus.in_valid = 1'b1;
    g = 0;
    do begin
      cycle();
      g++;
    end while (!accepted && g < 20);
    bus.in_valid = 1'b0;
    chk("accept_timeout", 64'(accepted), 64'(1));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 50) begin
      cycle();
      g++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] sd[8];
    int idx, cyc, n0, nerr, e1, e2;

    m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
    bus.in_valid = 1'b0; bus.code = '0; bus.out_ready = 1'b1; bus.clear_cnt = 1'b0;
    accepted = 1'b0; saw_low = 1'b0;
    cur_exp = '{default: '0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_data", 64'(bus.data), 64'(0));
    chk("rst_err_pos", 64'(bus.err_pos), 64'(0));
    chk("rst_flags", 64'({bus.single_err, bus.double_err}), 64'(0));
    chk("rst_cnts", 64'({bus.corr_cnt, bus.uncorr_cnt}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // clean word, two-edge latency from presentation to out_valid
    d = 39'h5A_5A5A_5A5A;
    prep(d, 0, 0, 0);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("lat_accept", 64'(accepted), 64'(1));
    chk("lat_edge1", 64'(bus.out_valid), 64'(0));
    cycle();
    chk("lat_edge2", 64'(bus.out_valid), 64'(1));
    drain();

    // single flip at 13, flip of the overall parity bit, double flip 5+20
    push_word(d, 1, 13, 0);
    drain();
    chk("corr_cnt_13", 64'(bus.corr_cnt), 64'(1));
    push_word(d, 1, 0, 0);
    drain();
    chk("corr_cnt_bit0", 64'(bus.corr_cnt), 64'(2));
    push_word(d, 2, 5, 20);
    drain();
    chk("uncorr_cnt_5_20", 64'(bus.uncorr_cnt), 64'(1));

    // 8 back-to-back words with a 3-cycle downstream stall
    for (int i = 0; i < 8; i++) sd[i] = DW'({$urandom(), $urandom()});
    n0 = n_out; idx = 0; cyc = 0; saw_low = 1'b0;
    while ((idx < 8 || q.size() > 0) && cyc < 100) begin
      bus.in_valid = (idx < 8);
      if (idx < 8) prep(sd[idx], 0, 0, 0);
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      cycle();
      if (accepted) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("stream_sent", 64'(idx), 64'(8));
    chk("stream_count", 64'(n_out - n0), 64'(8));
    chk("stream_ready_dropped", 64'(saw_low), 64'(1));

    // saturation of the 2-bit instance
    bus.clear_cnt = 1'b1;
    cycle();
    bus.clear_cnt = 1'b0;
    chk("clear_corr", 64'(bus.corr_cnt), 64'(0));
    for (int i = 0; i < 5; i++) push_word(DW'({$urandom(), $urandom()}), 1, int'($urandom_range(0, CW-1)), 0);
    drain();
    chk("sat_corr_w2", 64'(bus2.corr_cnt), 64'(3));
    chk("corr_after5", 64'(bus.corr_cnt), 64'(5));

    // clear in the same cycle as an error-word handshake
    bus.out_ready = 1'b0;
    push_word(DW'({$urandom(), $urandom()}), 1, 7, 0);
    cycle();
    cycle();
    chk("held_valid", 64'(bus.out_valid), 64'(1));
    bus.clear_cnt = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.clear_cnt = 1'b0;
    chk("clear_wins", 64'(bus.corr_cnt), 64'(0));
    chk("clear_wins_w2", 64'(bus2.corr_cnt), 64'(0));

    // randomized traffic: 0/1/2 errors, valid gaps, backpressure, rare clears
    idx = 0; cyc = 0; accepted = 1'b1;
    while ((idx < 60 || q.size() > 0) && cyc < 2000) begin
      if (accepted && idx < 60) begin
        nerr = int'($urandom_range(0, 2));
        e1 = int'($urandom_range(0, CW-1));
        do e2 = int'($urandom_range(0, CW-1)); while (e2 == e1);
        prep(DW'({$urandom(), $urandom()}), nerr, e1, e2);
      end
      bus.in_valid  = (idx < 60) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.clear_cnt = ($urandom_range(0, 15) == 0);
      cycle();
      if (accepted) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clear_cnt = 1'b0;
    chk("rand_sent", 64'(idx), 64'(60));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
